// File: rtl/ecc_check26.sv
// Hamming(31,26) read-path checker/corrector with a two-stage valid/ready pipeline
// and a saturating count of words whose syndrome was nonzero.
module ecc_check26 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      in_data,
  input  logic [4:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_data,
  output logic             out_err,
  output logic [4:0]       out_syndrome,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  // Data-bit coverage of each check bit.
  localparam logic [25:0] MaskP0 = 26'h2AAAD5B;
  localparam logic [25:0] MaskP1 = 26'h333366D;
  localparam logic [25:0] MaskP2 = 26'h3C3C78E;
  localparam logic [25:0] MaskP3 = 26'h3FC07F0;
  localparam logic [25:0] MaskP4 = 26'h3FFF800;

  // Map a syndrome (codeword position) to a one-hot data-bit flip mask.
  // Powers of two are check-bit positions and yield an empty mask.
  function automatic logic [25:0] flip_mask(input logic [4:0] s);
    logic [25:0] m;
    logic [4:0]  k;
    m = '0;
    k = '0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (s == 5'(p)) m[k] = 1'b1;
        k = k + 5'd1;
      end
    end
    return m;
  endfunction

  logic        s1_valid;
  logic [25:0] s1_data;
  logic [4:0]  s1_syn;
  logic        s2_valid;
  logic        s2_load;
  logic        s1_accept;
  logic [4:0]  in_parity;
  logic [4:0]  in_syn;
  logic [25:0] corr_data;

  always_comb begin
    in_parity[0] = ^(in_data & MaskP0);
    in_parity[1] = ^(in_data & MaskP1);
    in_parity[2] = ^(in_data & MaskP2);
    in_parity[3] = ^(in_data & MaskP3);
    in_parity[4] = ^(in_data & MaskP4);
    in_syn       = in_parity ^ in_code;
  end

  always_comb begin
    s2_load   = s1_valid && (!s2_valid || out_ready);
    in_ready  = !s1_valid || s2_load;
    s1_accept = in_valid && in_ready;
    corr_data = s1_data ^ flip_mask(s1_syn);
  end

  // Stage 1: captured word and its syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (s1_accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_syn   <= in_syn;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: corrected output, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      s2_valid     <= 1'b1;
      out_data     <= corr_data;
      out_err      <= (s1_syn != 5'd0);
      out_syndrome <= s1_syn;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

  // Clear has priority over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (s2_load && (s1_syn != 5'd0) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_check26.sv
// Directed bench for ecc_check26: two instances (default and 2-bit counter) share stimulus.
module tb_ecc_check26;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [25:0] in_data;
  logic [4:0]  in_code;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [25:0] out_data, out_data2;
  logic        out_err, out_err2;
  logic [4:0]  out_syndrome, out_syndrome2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  int checks;
  int errors;

  ecc_check26 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_syndrome(out_syndrome), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  ecc_check26 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_err(out_err2), .out_syndrome(out_syndrome2), .err_cnt(err_cnt2), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [25:0] d, input logic [4:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_code  = c;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic check_out(input string tag, input logic [25:0] d, input logic e,
                           input logic [4:0] s, input logic [15:0] c16, input logic [1:0] c2);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".data"}, {6'd0, out_data}, {6'd0, d});
    check({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
    check({tag, ".syn"}, {27'd0, out_syndrome}, {27'd0, s});
    check({tag, ".cnt"}, {16'd0, err_cnt}, {16'd0, c16});
    check({tag, ".cnt2"}, {30'd0, err_cnt2}, {30'd0, c2});
    check({tag, ".data2"}, {6'd0, out_data2}, {6'd0, d});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.data", {6'd0, out_data}, 32'd0);
    check("rst.cnt", {16'd0, err_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle.valid", {31'd0, out_valid}, 32'd0);

    // Clean and single-error words
    send(26'h0000001, 5'h03);  check_out("clean1", 26'h0000001, 1'b0, 5'd0, 16'd0, 2'd0);
    send(26'h3FFFFFF, 5'h1F);  check_out("clean2", 26'h3FFFFFF, 1'b0, 5'd0, 16'd0, 2'd0);
    send(26'h0000000, 5'h03);  check_out("s3", 26'h0000001, 1'b1, 5'd3, 16'd1, 2'd1);
    send(26'h0000000, 5'h1F);  check_out("s31", 26'h2000000, 1'b1, 5'd31, 16'd2, 2'd2);
    send(26'h0000000, 5'h10);  check_out("s16", 26'h0000000, 1'b1, 5'd16, 16'd3, 2'd3);
    send(26'h0000000, 5'h05);  check_out("s5", 26'h0000002, 1'b1, 5'd5, 16'd4, 2'd3);
    send(26'h0000000, 5'h06);  check_out("s6", 26'h0000004, 1'b1, 5'd6, 16'd5, 2'd3);

    // Clear coincides with an erroneous S2 load
    in_valid = 1'b1; in_data = '0; in_code = 5'h03;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_out("clr", 26'h0000001, 1'b1, 5'd3, 16'd0, 2'd0);
    tick();
    check("clr.drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: four words, three stalled cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 5'h03;
    tick();
    check("bp.rdyA", {31'd0, in_ready}, 32'd1);
    in_code = 5'h05;
    tick();
    check("bp.rdyB", {31'd0, in_ready}, 32'd0);
    in_code = 5'h06;
    tick();
    check("bp.holdC", {6'd0, out_data}, 32'h1);
    check("bp.rdyC", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp.holdD", {6'd0, out_data}, 32'h1);
    check("bp.vldD", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp.w1", {6'd0, out_data}, 32'h2);
    in_code = 5'h07;
    tick();
    check("bp.w2", {6'd0, out_data}, 32'h4);
    in_valid = 1'b0;
    tick();
    check("bp.w3", {6'd0, out_data}, 32'h8);
    check("bp.w3syn", {27'd0, out_syndrome}, 32'd7);
    tick();
    check("bp.empty", {31'd0, out_valid}, 32'd0);
    check("bp.cnt", {16'd0, err_cnt}, 32'd4);
    check("bp.cnt2", {30'd0, err_cnt2}, 32'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 5'h03;
    tick();
    in_code = 5'h05;
    tick();
    check("mid.full", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid.valid", {31'd0, out_valid}, 32'd0);
    check("mid.data", {6'd0, out_data}, 32'd0);
    check("mid.err", {31'd0, out_err}, 32'd0);
    check("mid.cnt", {16'd0, err_cnt}, 32'd0);
    check("mid.cnt2", {30'd0, err_cnt2}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post.v1", {31'd0, out_valid}, 32'd0);
    tick();
    check("post.v2", {31'd0, out_valid}, 32'd0);
    send(26'h0000001, 5'h03);  check_out("post.clean", 26'h0000001, 1'b0, 5'd0, 16'd0, 2'd0);
    send(26'h0000000, 5'h03);  check_out("post.err", 26'h0000001, 1'b1, 5'd3, 16'd1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ecc_check26.md
ECC_CHECK26 -- requirements
Module: ecc_check26

Interface
REQ-001 Parameter: CNT_W, default 16, width of the corrected-error counter.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  read word valid.
REQ-005 Port: in_ready  output  1  block accepts word this cycle.
REQ-006 Port: in_data  input  26  stored data bits d[25:0].
REQ-007 Port: in_code  input  5  stored check bits {p4,p3,p2,p1,p0}.
REQ-008 Port: out_valid  output  1  corrected word valid.
REQ-009 Port: out_ready  input  1  consumer accepts word.
REQ-010 Port: out_data  output  26  corrected data.
REQ-011 Port: out_err  output  1  nonzero syndrome seen for this word.
REQ-012 Port: out_syndrome  output  5  syndrome of this word.
REQ-013 Port: err_cnt  output  CNT_W  saturating count of words with nonzero syndrome.
REQ-014 Port: cnt_clr  input  1  synchronous clear of err_cnt.

Function
REQ-015 Parity recompute SHALL use the team Hamming(31,26) equations: p0 = d0^d1^d3^d4^d6^d8^d10^d11^d13^d15^d17^d19^d21^d23^d25; p1 = d0^d2^d3^d5^d6^d9^d10^d12^d13^d16^d17^d20^d21^d24^d25; p2 = d1^d2^d3^d7..d10^d14..d17^d22..d25; p3 = d4..d10^d18..d25; p4 = d11..d25.
REQ-016 Syndrome SHALL be {p4..p0 recomputed} XOR in_code.
REQ-017 Syndrome 0: data passes unchanged, out_err=0.
REQ-018 Syndrome in {1,2,4,8,16}: check-bit error; data unchanged, out_err=1.
REQ-019 Other syndrome s (codeword position): flip d[k], k = s - (count of powers of two <= s) - 1 (s=3->k0, s=5->k1, s=31->k25); out_err=1.
REQ-020 Multi-bit errors SHALL be handled per REQ-017..019 (no double-error detection); no other behaviour.
REQ-021 Pipeline SHALL be two register stages: S1 holds data, code and syndrome; S2 holds out_data, out_err, out_syndrome; out_valid = S2 valid.
REQ-022 Latency: word accepted at edge N appears on outputs after edge N+1 when out_ready held high; throughput one word per cycle.
REQ-023 S2 loads when S1 valid and (S2 empty or out_ready); in_ready = !S1_valid or S2 loads this cycle.
REQ-024 Output fields SHALL hold stable while out_valid=1 and out_ready=0; no word dropped or duplicated.
REQ-025 in_valid with in_ready=0 SHALL be ignored; upstream holds data.
REQ-026 err_cnt SHALL increment by 1 on each S2 load whose syndrome is nonzero, saturating at all-ones.
REQ-027 cnt_clr=1 SHALL set err_cnt to 0 next edge; clear wins over simultaneous increment.
REQ-028 cnt_clr SHALL not affect the data pipeline.

Reset
REQ-029 rst=1 SHALL immediately clear S1/S2 valid, out_valid=0, out_data=0, out_err=0, out_syndrome=0, err_cnt=0.
REQ-030 During rst, in_ready=1 is permitted but no word SHALL be captured; words in flight at reset assertion are discarded.
REQ-031 First capture SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-032 Clean word: in_data=26'h0000001, in_code=5'h03, out_ready=1 -> two edges later out_data=26'h0000001, out_err=0, out_syndrome=0, err_cnt unchanged.
REQ-033 Data error: in_data=0, in_code=5'h03 -> out_data=26'h0000001, out_syndrome=3, out_err=1, err_cnt+1; in_data=0, in_code=5'h1F -> out_data=26'h2000000, syndrome 31.
REQ-034 Check-bit error: in_data=0, in_code=5'h10 -> out_data=0, out_syndrome=16, out_err=1.
REQ-035 Backpressure: stream 4 words, out_ready=0 for 3 cycles -> in_ready drops after S1 and S2 fill, outputs held, all 4 words delivered in order once out_ready=1.
REQ-036 Counter: CNT_W=2, send 5 erroneous words -> err_cnt saturates at 3; cnt_clr asserted same cycle as an erroneous S2 load -> err_cnt=0.
REQ-037 Reset mid-stream: assert rst with both stages valid -> out_valid=0 and err_cnt=0 immediately, no stale word after deassert.
